// File: rtl/dataflow_reconfig_scheduler.sv
// Reconfiguration sequencer for the multi-dataflow kernel: gates and drains
// in-flight tokens, switches the network ID, waits a settle interval, then acknowledges.
module dataflow_reconfig_scheduler #(
    parameter int ID_WIDTH      = 8,
    parameter int NUM_CFG       = 2,
    parameter int CNT_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_req_i,
    input  logic [ID_WIDTH-1:0] cfg_id_i,
    output logic                cfg_ack_o,
    output logic                cfg_err_o,
    input  logic                in_fire_i,
    input  logic                out_fire_i,
    output logic                in_gate_o,
    output logic [ID_WIDTH-1:0] id_o,
    output logic                cfg_valid_o,
    output logic                busy_o
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   count;
    logic [ID_WIDTH-1:0]    pending_id;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   count_full;
    logic                   count_empty;
    logic                   id_legal;

    assign count_full  = (count == '1);
    assign count_empty = (count == '0);
    assign id_legal    = (cfg_id_i != '0) && (cfg_id_i <= ID_WIDTH'(NUM_CFG));
    assign in_gate_o   = (state != IDLE) || !cfg_valid_o || count_full;

    // Saturating token counter; tokens accepted despite the gate are still tracked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (in_fire_i && !out_fire_i && !count_full) begin
            count <= count + 1'b1;
        end else if (out_fire_i && !in_fire_i && !count_empty) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            id_o        <= '0;
            pending_id  <= '0;
            settle_cnt  <= '0;
            cfg_valid_o <= 1'b0;
            cfg_ack_o   <= 1'b0;
            cfg_err_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            cfg_ack_o <= 1'b0;
            cfg_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Ignoring the request during its own ack cycle stops a held request re-firing.
                    if (cfg_req_i && !cfg_ack_o) begin
                        if (!id_legal) begin
                            cfg_ack_o <= 1'b1;
                            cfg_err_o <= 1'b1;
                        end else if (cfg_id_i == id_o && cfg_valid_o) begin
                            cfg_ack_o <= 1'b1;
                        end else begin
                            pending_id  <= cfg_id_i;
                            cfg_valid_o <= 1'b0;
                            busy_o      <= 1'b1;
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (count_empty) state <= SWITCH;
                end
                SWITCH: begin
                    id_o       <= pending_id;
                    settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                    if (SETTLE_CYCLES == 0) begin
                        cfg_valid_o <= 1'b1;
                        cfg_ack_o   <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt <= SETTLE_W'(1)) begin
                        cfg_valid_o <= 1'b1;
                        cfg_ack_o   <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataflow_reconfig_scheduler.sv
// Scoreboard bench: request stimulus queues the expected ack, a negedge monitor checks it.
module tb_dataflow_reconfig_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_req_i;
    logic [7:0] cfg_id_i;
    logic       cfg_ack_o;
    logic       cfg_err_o;
    logic       in_fire_i;
    logic       out_fire_i;
    logic       in_gate_o;
    logic [7:0] id_o;
    logic       cfg_valid_o;
    logic       busy_o;

    typedef struct {
        logic       err;
        logic [7:0] id;
        logic       valid;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    dataflow_reconfig_scheduler #(
        .ID_WIDTH(8), .NUM_CFG(2), .CNT_WIDTH(8), .SETTLE_CYCLES(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_req_i(cfg_req_i), .cfg_id_i(cfg_id_i),
        .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o), .in_fire_i(in_fire_i),
        .out_fire_i(out_fire_i), .in_gate_o(in_gate_o), .id_o(id_o),
        .cfg_valid_o(cfg_valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue a request in the current cycle (cycle 0); out_fire pulses in cycles 1..n_out.
    task automatic do_req(input logic [7:0] id, input logic err, input logic [7:0] exp_id,
                          input logic [7:0] prev_id, input int lat, input int n_out);
        exp_t e;
        bit   seen;
        cfg_req_i = 1'b1;
        cfg_id_i  = id;
        e.err = err; e.id = exp_id; e.valid = 1'b1; e.cyc = cyc + lat;
        q.push_back(e);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            tick();
            out_fire_i = (k <= n_out);
            if (lat >= 5 && k == 1) begin
                check("gate_while_busy", 32'(in_gate_o), 32'd1);
                check("busy_while_busy", 32'(busy_o), 32'd1);
            end
            if (lat >= 5 && k == lat - 3) check("id_before_switch", 32'(id_o), 32'(prev_id));
            if (lat >= 5 && k == lat - 2) check("id_after_switch", 32'(id_o), 32'(exp_id));
            if (cfg_ack_o) seen = 1'b1;
        end
        out_fire_i = 1'b0;
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        tick();
        cfg_req_i = 1'b0;
        cfg_id_i  = '0;
        tick();
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (cfg_err_o && !cfg_ack_o) check("err_without_ack", 32'd1, 32'd0);
        if (cfg_ack_o) begin
            if (q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                check("ack_err", 32'(cfg_err_o), 32'(e.err));
                check("ack_id", 32'(id_o), 32'(e.id));
                check("ack_valid", 32'(cfg_valid_o), 32'(e.valid));
                check("ack_busy", 32'(busy_o), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; cfg_req_i = 1'b0; cfg_id_i = '0; in_fire_i = 1'b0; out_fire_i = 1'b0;
        #2;
        check("rst_id", 32'(id_o), 32'd0);
        check("rst_valid", 32'(cfg_valid_o), 32'd0);
        check("rst_ack", 32'(cfg_ack_o), 32'd0);
        check("rst_err", 32'(cfg_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_gate", 32'(in_gate_o), 32'd1);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();

        // Empty pipe, ID 1: id_o changes in cycle 3, ack in cycle 5.
        do_req(8'd1, 1'b0, 8'd1, 8'd0, 5, 0);
        check("gate_open_after_cfg", 32'(in_gate_o), 32'd0);

        // Three tokens in flight, drained by out_fire in cycles 1..3.
        in_fire_i = 1'b1;
        repeat (3) tick();
        in_fire_i = 1'b0;
        do_req(8'd2, 1'b0, 8'd2, 8'd1, 8, 3);

        // Illegal IDs.
        do_req(8'd0, 1'b1, 8'd2, 8'd2, 1, 0);
        do_req(8'd3, 1'b1, 8'd2, 8'd2, 1, 0);
        check("busy_after_err", 32'(busy_o), 32'd0);
        check("valid_after_err", 32'(cfg_valid_o), 32'd1);

        // Same ID already active; held request must not be accepted again.
        do_req(8'd2, 1'b0, 8'd2, 8'd2, 1, 0);
        check("busy_after_same", 32'(busy_o), 32'd0);
        check("gate_after_same", 32'(in_gate_o), 32'd0);

        // Count 2, simultaneous fire keeps it at 2: drain ends after out_fire in cycles 1,2.
        in_fire_i = 1'b1;
        repeat (2) tick();
        out_fire_i = 1'b1;
        tick();
        in_fire_i = 1'b0; out_fire_i = 1'b0;
        do_req(8'd1, 1'b0, 8'd1, 8'd2, 7, 2);

        // out_fire at count 0 is ignored, so one in_fire leaves exactly one token.
        out_fire_i = 1'b1;
        repeat (2) tick();
        out_fire_i = 1'b0;
        in_fire_i = 1'b1;
        tick();
        in_fire_i = 1'b0;
        do_req(8'd2, 1'b0, 8'd2, 8'd1, 6, 1);

        // Saturation at 255.
        in_fire_i = 1'b1;
        repeat (254) tick();
        check("gate_at_254", 32'(in_gate_o), 32'd0);
        tick();
        check("gate_at_255", 32'(in_gate_o), 32'd1);
        tick();
        check("gate_no_wrap", 32'(in_gate_o), 32'd1);
        in_fire_i = 1'b0;
        out_fire_i = 1'b1;
        tick();
        check("gate_after_dec", 32'(in_gate_o), 32'd0);
        repeat (254) tick();
        out_fire_i = 1'b0;
        tick();

        // Reset asserted during SETTLE (cycle 3): no ack, all reset values.
        cfg_req_i = 1'b1;
        cfg_id_i  = 8'd1;
        repeat (3) tick();
        check("busy_in_settle", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_id", 32'(id_o), 32'd0);
        check("midrst_valid", 32'(cfg_valid_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_gate", 32'(in_gate_o), 32'd1);
        cfg_req_i = 1'b0;
        cfg_id_i  = '0;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        check("no_ack_after_rst", 32'(cfg_ack_o), 32'd0);
        do_req(8'd1, 1'b0, 8'd1, 8'd0, 5, 0);

        repeat (5) tick();
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
